// File: rtl/eth_arp_pkg.sv
// Shared ARP types, opcodes and state encodings for the ARP transmit sequencer.
package eth_arp_pkg;

  typedef logic [47:0] mac_t;
  typedef logic [31:0] ip_t;

  localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY   = 16'd2;

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_START = 2'd1;
  localparam logic [1:0] T_BUSY  = 2'd2;
  localparam logic [1:0] T_GAP   = 2'd3;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_PEND  = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;

  // Per-frame fields that differ between reply and request frames.
  typedef struct packed {
    logic [15:0] opcode;
    mac_t        dest_mac;
    ip_t         dest_ip;
  } arp_fields_t;

  // Retry counter width; at least one bit even when no retries are allowed.
  function automatic int retry_w(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/arp_tx_ctrl_if.sv
// Bundle between the ARP sequencer and the ARP transmit datapath.
interface arp_tx_ctrl_if;
  import eth_arp_pkg::*;

  logic        arp_enable;
  logic        arp_start;
  logic [15:0] arp_opcode;
  mac_t        arp_srcMac;
  ip_t         arp_srcIP;
  mac_t        arp_destMac;
  ip_t         arp_destIP;

  // A stream beat transfers only in a cycle with m_axis_tvalid && m_axis_tready
  // both high; the frame ends on the transferred beat that carries m_axis_tlast.
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (
    output arp_enable, arp_start, arp_opcode, arp_srcMac, arp_srcIP,
           arp_destMac, arp_destIP,
    input  m_axis_tvalid, m_axis_tready, m_axis_tlast
  );

  modport slave (
    input  arp_enable, arp_start, arp_opcode, arp_srcMac, arp_srcIP,
           arp_destMac, arp_destIP,
    output m_axis_tvalid, m_axis_tready, m_axis_tlast
  );

endinterface

// File: rtl/arp_retry_timer.sv
// Reply timeout counter and retry count for the ARP resolver.
module arp_retry_timer
  import eth_arp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 125000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_load,
  input  logic                           i_run,
  input  logic                           i_clear,
  input  logic                           i_inc,
  output logic                           o_expire,
  output logic [retry_w(MAX_RETRY)-1:0]  o_retry_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = retry_w(MAX_RETRY);

  logic [TW-1:0] r_cnt;
  logic [RW-1:0] r_retry;

  // Loaded with TIMEOUT-1 so expiry lands exactly TIMEOUT cycles after load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      if (i_load)
        r_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (i_run && (r_cnt != '0))
        r_cnt <= r_cnt - TW'(1);
      if (i_clear)
        r_retry <= '0;
      else if (i_inc)
        r_retry <= r_retry + RW'(1);
    end
  end

  assign o_expire    = i_run && (r_cnt == '0);
  assign o_retry_cnt = r_retry;

endmodule

// File: rtl/arp_tx_ctrl.sv
// ARP transmit sequencer: one-deep reply slot, request resolver with retry,
// and the frame FSM that drives the ARP datapath fields and start strobe.
module arp_tx_ctrl
  import eth_arp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 125000000,
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = 4
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  mac_t        local_mac,
  input  ip_t         local_ip,
  input  logic        rx_arp_valid,
  input  logic [15:0] rx_opcode,
  input  mac_t        rx_srcMac,
  input  ip_t         rx_srcIP,
  input  ip_t         rx_destIP,
  input  logic        req_start,
  input  ip_t         req_ip,
  output logic        resolve_busy,
  output logic        resolve_done,
  output mac_t        resolve_mac,
  output logic        resolve_fail,
  output logic        reply_drop,
  output logic        arp_enable,
  output logic        arp_start,
  output logic [15:0] arp_opcode,
  output mac_t        arp_srcMac,
  output ip_t         arp_srcIP,
  output mac_t        arp_destMac,
  output ip_t         arp_destIP,
  input  logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        m_axis_tlast,
  output logic [1:0]  o_dbg_tx_state,
  output logic [1:0]  o_dbg_rs_state
);

  localparam int RW = retry_w(MAX_RETRY);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [1:0]    r_tx_state, r_rs_state;
  logic          r_slot_full, r_tx_is_reply;
  mac_t          r_slot_mac, r_src_mac, r_resolve_mac;
  ip_t           r_slot_ip, r_src_ip, r_req_ip;
  logic          r_req_sent, r_pend_d;
  logic          r_done, r_fail, r_drop;
  logic [GW-1:0] r_gap_cnt;
  arp_fields_t   r_fld;

  logic          w_reply_trig, w_match, w_frame_end, w_req_owed;
  logic          w_take_reply, w_take_req, w_arm, w_expire, w_retry_ok;
  logic          w_rs_start, w_retry;
  logic [RW-1:0] w_retry_cnt;

  assign w_reply_trig = rx_arp_valid && (rx_opcode == ARP_OP_REQUEST) && (rx_destIP == local_ip);
  assign w_match      = rx_arp_valid && (rx_opcode == ARP_OP_REPLY) && (rx_srcIP == r_req_ip) &&
                        ((r_rs_state == R_PEND) || (r_rs_state == R_WAIT));
  assign w_frame_end  = (r_tx_state == T_BUSY) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
  // r_pend_d delays request pickup one cycle behind R_PEND becoming visible.
  assign w_req_owed   = (r_rs_state == R_PEND) && !r_req_sent && r_pend_d;
  assign w_take_reply = (r_tx_state == T_IDLE) && r_slot_full;
  assign w_take_req   = (r_tx_state == T_IDLE) && !r_slot_full && w_req_owed;
  // A request frame that ends after a match must not re-arm the timer.
  assign w_arm        = w_frame_end && r_req_sent && (r_rs_state == R_PEND) && !w_match;
  assign w_retry_ok   = (w_retry_cnt < RW'(MAX_RETRY));
  assign w_rs_start   = (r_rs_state == R_IDLE) && req_start;
  assign w_retry      = (r_rs_state == R_WAIT) && w_expire && !w_match && w_retry_ok;

  arp_retry_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRY      (MAX_RETRY)
  ) u_retry_timer (
    .clk         (s_axis_aclk),
    .rst         (s_axis_areset),
    .i_load      (w_arm),
    .i_run       (r_rs_state == R_WAIT),
    .i_clear     (w_rs_start),
    .i_inc       (w_retry),
    .o_expire    (w_expire),
    .o_retry_cnt (w_retry_cnt)
  );

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_rs_state    <= R_IDLE;
      r_req_ip      <= '0;
      r_req_sent    <= 1'b0;
      r_pend_d      <= 1'b0;
      r_resolve_mac <= '0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_done   <= w_match;
      r_fail   <= 1'b0;
      r_pend_d <= (r_rs_state == R_PEND);
      if (w_match || w_frame_end)
        r_req_sent <= 1'b0;
      else if (w_take_req)
        r_req_sent <= 1'b1;
      if (w_match)
        r_resolve_mac <= rx_srcMac;
      case (r_rs_state)
        R_IDLE: if (req_start) begin
          r_req_ip   <= req_ip;
          r_rs_state <= R_PEND;
        end
        R_PEND: begin
          if (w_match)    r_rs_state <= R_IDLE;
          else if (w_arm) r_rs_state <= R_WAIT;
        end
        R_WAIT: begin
          if (w_match) begin
            r_rs_state <= R_IDLE;
          end else if (w_expire) begin
            if (w_retry_ok) begin
              r_rs_state <= R_PEND;
            end else begin
              r_fail     <= 1'b1;
              r_rs_state <= R_IDLE;
            end
          end
        end
        default: r_rs_state <= R_IDLE;
      endcase
    end
  end

  // Reply slot: a trigger arriving while full is dropped, even in the clear cycle.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_slot_full <= 1'b0;
      r_slot_mac  <= '0;
      r_slot_ip   <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= w_reply_trig && r_slot_full;
      if (w_reply_trig && !r_slot_full) begin
        r_slot_full <= 1'b1;
        r_slot_mac  <= rx_srcMac;
        r_slot_ip   <= rx_srcIP;
      end else if ((r_tx_state == T_START) && r_tx_is_reply) begin
        r_slot_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_tx_state    <= T_IDLE;
      r_tx_is_reply <= 1'b0;
      r_fld         <= '0;
      r_src_mac     <= '0;
      r_src_ip      <= '0;
      r_gap_cnt     <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (w_take_reply) begin
            r_fld         <= '{opcode: ARP_OP_REPLY, dest_mac: r_slot_mac, dest_ip: r_slot_ip};
            r_tx_is_reply <= 1'b1;
          end else if (w_take_req) begin
            r_fld         <= '{opcode: ARP_OP_REQUEST, dest_mac: '0, dest_ip: r_req_ip};
            r_tx_is_reply <= 1'b0;
          end
          if (w_take_reply || w_take_req) begin
            r_src_mac  <= local_mac;
            r_src_ip   <= local_ip;
            r_tx_state <= T_START;
          end
        end
        T_START: r_tx_state <= T_BUSY;
        T_BUSY: if (w_frame_end) begin
          r_gap_cnt  <= GW'(GAP_CYCLES - 1);
          r_tx_state <= T_GAP;
        end
        T_GAP: begin
          if (r_gap_cnt == '0) r_tx_state <= T_IDLE;
          else                 r_gap_cnt  <= r_gap_cnt - GW'(1);
        end
      endcase
    end
  end

  assign arp_start      = (r_tx_state == T_START);
  assign arp_enable     = (r_tx_state == T_START) || (r_tx_state == T_BUSY);
  assign arp_opcode     = r_fld.opcode;
  assign arp_destMac    = r_fld.dest_mac;
  assign arp_destIP     = r_fld.dest_ip;
  assign arp_srcMac     = r_src_mac;
  assign arp_srcIP      = r_src_ip;
  assign resolve_busy   = (r_rs_state != R_IDLE);
  assign resolve_done   = r_done;
  assign resolve_fail   = r_fail;
  assign resolve_mac    = r_resolve_mac;
  assign reply_drop     = r_drop;
  assign o_dbg_tx_state = r_tx_state;
  assign o_dbg_rs_state = r_rs_state;

endmodule
